// File: rtl/flash_rd_pkg.sv
// -----------------------------------------------------------------------------
// flash_rd_pkg
// Shared types and constants for the SPI Fast Read word controller that talks
// to the external SST26WF080B program flash.
//   state_e        controller states
//   CMD_FAST_READ  SPI Fast Read opcode
//   SEND_BITS      command + address + dummy bits shifted out per transaction
//   RECV_BITS      data bits shifted in per word
//   FDO_IDLE       pad output levels (WP#/HOLD# held inactive, SI low)
//   FDOE_*         pad output enables with CE# active / inactive
//   bswap32        byte reversal (wire order is big-endian, rdata little-endian)
// -----------------------------------------------------------------------------
package flash_rd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        RECV,
        HOLD,
        DESEL
    } state_e;

    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam int         SEND_BITS     = 40;
    localparam int         RECV_BITS     = 32;

    localparam logic [3:0] FDO_IDLE      = 4'b1100;
    localparam logic [3:0] FDOE_ACTIVE   = 4'b1101;
    localparam logic [3:0] FDOE_IDLE     = 4'b1100;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/flash_fastread_ctrl_sck_phase_gen.sv
// -----------------------------------------------------------------------------
// sck_phase_gen
// SCK phase generator. While en is high it produces a square wave with a
// half-period of DIV HCLK cycles, low phase first. When en is low the clock
// parks low and the phase counter restarts, so the first cycle after enable
// is always the first cycle of a low phase.
//   HCLK, HRESET  clock, synchronous active-high reset
//   en            run the SCK
//   fsclk         flash SCK (straight from a flop, glitch-free)
//   shift_tick    first cycle of a low phase (new SI bit is presented)
//   sample_tick   last cycle of a high phase (SO is sampled at its end)
// -----------------------------------------------------------------------------
module sck_phase_gen #(
    parameter int DIV = 1
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic en,
    output logic fsclk,
    output logic shift_tick,
    output logic sample_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          phase;     // 0 = low phase, 1 = high phase
    logic          last;

    assign last = (cnt == CW'(DIV - 1));

    // NOTE: every flop is written with <= so all registers update together
    // at the edge regardless of the order the blocks are evaluated in.
    always_ff @(posedge HCLK) begin
        if (HRESET || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (last) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign fsclk       = phase;
    assign shift_tick  = en & ~phase & (cnt == '0);
    assign sample_tick = en &  phase & last;

endmodule

// File: rtl/flash_fastread_ctrl.sv
// -----------------------------------------------------------------------------
// flash_fastread_ctrl
// 32-bit word reader for the SST26WF080B using SPI Fast Read (0x0B) on
// IO0/IO1. CE# is held low after a word so that the next sequential word is
// streamed without a new command; any other address closes the transaction,
// keeps CE# high for T_CSH cycles and starts over.
//   HCLK, HRESET  clock, synchronous active-high reset
//   req, addr     read request and byte address (held until rvalid)
//   rvalid        one-cycle pulse, rdata holds the requested word
//   rdata         read word, byte at addr in [7:0]
//   fsclk, fcen   flash SCK and CE#
//   fdo, fdoe     pad outputs / output enables (SI on [0])
//   fdi           pad inputs (SO on [1])
// -----------------------------------------------------------------------------
module flash_fastread_ctrl
    import flash_rd_pkg::*;
#(
    parameter int DIV   = 1,
    parameter int T_CSH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req,
    input  logic [23:0] addr,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        fsclk,
    output logic        fcen,
    output logic [3:0]  fdo,
    output logic [3:0]  fdoe,
    input  logic [3:0]  fdi
);

    localparam int CSW = (T_CSH > 1) ? $clog2(T_CSH) : 1;

    state_e          state, next_state;
    logic [39:0]     sr;          // outgoing cmd/addr/dummy, MSB on SI
    logic [31:0]     rx;          // incoming bits, first bit at the MSB
    logic [5:0]      bit_cnt;     // bits still to be started in this phase
    logic [CSW-1:0]  csh_cnt;
    logic [21:0]     last_idx;    // word index of the last completed read
    logic            fcen_q;

    logic            sck_en, shift_tick, sample_tick;
    logic            load_cmd, load_recv, done, enter_desel;
    logic            seq_ok;

    logic            unused_inputs;
    assign unused_inputs = ^{fdi[3:2], fdi[0], addr[1:0]};

    assign sck_en = (state == SEND) || (state == RECV);

    sck_phase_gen #(.DIV(DIV)) u_sck (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .en          (sck_en),
        .fsclk       (fsclk),
        .shift_tick  (shift_tick),
        .sample_tick (sample_tick)
    );

    // Streaming only continues to the next word index; the top index never
    // continues because the flash wraps there.
    assign seq_ok = (addr[23:2] == last_idx + 22'd1) && (last_idx != '1);

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state and all strobes get a default before the case so no
    // path leaves them unassigned, which would infer latches.
    always_comb begin
        next_state  = state;
        load_cmd    = 1'b0;
        load_recv   = 1'b0;
        done        = 1'b0;
        enter_desel = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = SEND;
                    load_cmd   = 1'b1;
                end
            end
            SEND: begin
                if (sample_tick && bit_cnt == '0) begin
                    next_state = RECV;
                    load_recv  = 1'b1;
                end
            end
            RECV: begin
                if (sample_tick && bit_cnt == '0) begin
                    next_state = HOLD;
                    done       = 1'b1;
                end
            end
            HOLD: begin
                // The request still on the bus during the rvalid cycle is the
                // one just served, so it is not a new request.
                if (req && !rvalid) begin
                    if (seq_ok) begin
                        next_state = RECV;
                        load_recv  = 1'b1;
                    end else begin
                        next_state  = DESEL;
                        enter_desel = 1'b1;
                    end
                end
            end
            DESEL: begin
                if (csh_cnt == '0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the shift register is reset along with the rest of the datapath
    // because SI is taken straight from its MSB; clearing it keeps SI low
    // outside SEND without extra gating.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sr       <= '0;
            rx       <= '0;
            bit_cnt  <= '0;
            csh_cnt  <= '0;
            last_idx <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            fcen_q   <= 1'b1;
        end else begin
            rvalid <= done;
            // CE# is registered from the next state so it cannot glitch.
            fcen_q <= !(next_state inside {SEND, RECV, HOLD});

            if (load_cmd)
                sr <= {CMD_FAST_READ, addr[23:2], 2'b00, 8'h00};
            else if (state == SEND && sample_tick)
                sr <= {sr[38:0], 1'b0};

            if (load_cmd)
                bit_cnt <= 6'(SEND_BITS);
            else if (load_recv)
                bit_cnt <= 6'(RECV_BITS);
            else if (shift_tick)
                bit_cnt <= bit_cnt - 1'b1;

            if (state == RECV && sample_tick)
                rx <= {rx[30:0], fdi[1]};

            if (done) begin
                rdata    <= bswap32({rx[30:0], fdi[1]});
                last_idx <= addr[23:2];
            end

            if (enter_desel)
                csh_cnt <= CSW'(T_CSH - 1);
            else if (state == DESEL && csh_cnt != '0)
                csh_cnt <= csh_cnt - 1'b1;
        end
    end

    assign fcen = fcen_q;
    assign fdo  = {FDO_IDLE[3:1], sr[39]};
    assign fdoe = fcen_q ? FDOE_IDLE : FDOE_ACTIVE;

endmodule
